// File: rtl/mul2_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// mul2_seq_ctrl_if
//   Request/result handshake between a requesting unit and the mul2_seq_ctrl
//   sequencer.
//
//   start  requester -> sequencer   start a multiply (sampled only when idle)
//   a, b   requester -> sequencer   WIDTH-bit unsigned operands
//   ack    requester -> sequencer   result consumed (honoured while valid=1)
//   busy   sequencer -> requester   job in flight or result pending
//   valid  sequencer -> requester   p holds a finished product
//   p      sequencer -> requester   2*WIDTH-bit product
//
//   master: the requesting unit.  slave: the sequencer.
// ---------------------------------------------------------------------------
interface mul2_seq_ctrl_if #(
    parameter int WIDTH = 8
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic [WIDTH-1:0]     b;
    logic                 ack;
    logic                 busy;
    logic                 valid;
    logic [2*WIDTH-1:0]   p;

    modport master (
        output start, a, b, ack,
        input  busy, valid, p
    );

    modport slave (
        input  start, a, b, ack,
        output busy, valid, p
    );
endinterface

// File: rtl/mul2_seq_ctrl.sv
// ---------------------------------------------------------------------------
// mul2_seq_ctrl
//   Computes a WIDTH x WIDTH unsigned product by stepping one shared external
//   2x2-bit combinational multiplier across every pair of 2-bit operand
//   digits and shift-accumulating the 4-bit partial products.
//
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   req    slave modport of mul2_seq_ctrl_if (start/a/b/ack in,
//                                             busy/valid/p out)
//   mx     out  digit j of the latched multiplicand, to multiplier x
//   my     out  digit i of the latched multiplier, to multiplier y
//   mp     in   4-bit product from the external multiplier (same cycle)
//
//   Flow: IDLE --start--> RUN (D*D cycles, one digit pair each) --> DONE
//         DONE --ack--> IDLE.  A zero operand skips RUN entirely.
// ---------------------------------------------------------------------------
module mul2_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    mul2_seq_ctrl_if.slave req,
    output logic [1:0]     mx,
    output logic [1:0]     my,
    input  logic [3:0]     mp
);
    localparam int D  = WIDTH / 2;
    localparam int IW = (D > 1) ? $clog2(D) : 1;
    localparam int PW = 2 * WIDTH;
    localparam logic [IW-1:0] LAST = IW'(D - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0] a_lat, b_lat;
    logic [IW-1:0]    i, j;
    logic [PW-1:0]    acc, acc_sum, term, p_q;
    logic [IW+1:0]    sh;
    logic             accept, op_zero, last_pair;

    assign accept    = (state == S_IDLE) && req.start;
    assign op_zero   = (req.a == '0) || (req.b == '0);
    assign last_pair = (i == LAST) && (j == LAST);

    // Partial product weight is 4^(i+j): shift by 2*(i+j) bits.
    assign sh      = ({2'b00, i} + {2'b00, j}) << 1;
    assign term    = PW'(mp) << sh;
    assign acc_sum = acc + term;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nx;
    end

    // ---------------- next state ----------------
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept)     state_nx = op_zero ? S_DONE : S_RUN;
            S_RUN:  if (last_pair)  state_nx = S_DONE;
            // ack wins over a simultaneous start; start is not queued.
            S_DONE: if (req.ack)    state_nx = S_IDLE;
            default:                state_nx = S_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_lat <= '0;
            b_lat <= '0;
            acc   <= '0;
            p_q   <= '0;
            i     <= '0;
            j     <= '0;
        end else if (accept) begin
            // p clears here, so the zero-skip path presents 0 with no extra work.
            a_lat <= req.a;
            b_lat <= req.b;
            acc   <= '0;
            p_q   <= '0;
            i     <= '0;
            j     <= '0;
        end else if (state == S_RUN) begin
            acc <= acc_sum;
            if (last_pair) p_q <= acc_sum;
            if (j == LAST) begin
                j <= '0;
                i <= i + IW'(1);
            end else begin
                j <= j + IW'(1);
            end
        end
    end

    // Digit select from registered indices; forced to 0 outside RUN so the
    // shared multiplier sees quiet inputs when this block is not using it.
    always_comb begin
        mx = 2'b00;
        my = 2'b00;
        if (state == S_RUN) begin
            mx = a_lat[2*j +: 2];
            my = b_lat[2*i +: 2];
        end
    end

    assign req.busy  = (state != S_IDLE);
    assign req.valid = (state == S_DONE);
    assign req.p     = p_q;

endmodule

// File: tb/tb_mul2_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mul2_seq_ctrl
//   Self-checking bench for mul2_seq_ctrl (WIDTH=8).  Expected values come
//   from plain arithmetic: p = a*b, latency = 17 (or 1 for a zero operand),
//   and RUN cycle n presents {b digit n/4, a digit n%4}.
// ---------------------------------------------------------------------------
module tb_mul2_seq_ctrl;
    localparam int W = 8;
    localparam int D = W / 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mx, my;
    logic [3:0] mp;

    int total = 0;
    int bad   = 0;

    mul2_seq_ctrl_if #(.WIDTH(W)) bus ();

    mul2_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (bus.slave),
        .mx    (mx),
        .my    (my),
        .mp    (mp)
    );

    // The external 2x2 multiplier.
    assign mp = 4'(mx) * 4'(my);

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] exp_digits(input logic [7:0] av, input logic [7:0] bv, input int n);
        logic [7:0] da, db;
        da = (av >> (2 * (n % D))) & 8'd3;
        db = (bv >> (2 * (n / D))) & 8'd3;
        return {db[1:0], da[1:0]};
    endfunction

    // Full job: start, track every RUN cycle, check latency/result, hold for
    // dly cycles with ack low, then acknowledge.
    task automatic run_job(input logic [7:0] av, input logic [7:0] bv, input int dly);
        int  lat;
        bit  zp;
        zp = (av == 0) || (bv == 0);
        bus.start = 1'b1;
        bus.a     = av;
        bus.b     = bv;
        tick();
        bus.start = 1'b0;
        bus.a     = 8'($urandom);
        bus.b     = 8'($urandom);
        lat = 1;
        while (!bus.valid && lat < 40) begin
            if (zp) chk("mxmy_zero", {my, mx}, 0);
            else    chk("digit", {my, mx}, exp_digits(av, bv, lat - 1));
            tick();
            lat++;
        end
        chk("latency", lat, zp ? 1 : D * D + 1);
        chk("p", bus.p, 64'(av) * 64'(bv));
        chk("mxmy_done", {my, mx}, 0);
        repeat (dly) begin
            tick();
            chk("valid_hold", bus.valid, 1);
            chk("p_hold", bus.p, 64'(av) * 64'(bv));
        end
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("valid_clr", bus.valid, 0);
        chk("busy_clr", bus.busy, 0);
    endtask

    initial begin
        int lat;
        logic [7:0] ra, rb;

        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.ack   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.valid, 0);
        chk("rst_p", bus.p, 0);
        chk("rst_mxmy", {my, mx}, 0);
        rst_n = 1'b1;
        tick();

        // Directed jobs
        run_job(8'd13, 8'd11, 5);
        run_job(8'hFF, 8'hFF, 0);
        run_job(8'd0, 8'd200, 2);
        run_job(8'd77, 8'd0, 0);

        // start pulse mid-RUN must be ignored
        bus.start = 1'b1; bus.a = 8'd9; bus.b = 8'd7;
        tick();
        bus.start = 1'b0;
        lat = 1;
        repeat (3) begin tick(); lat++; end
        bus.start = 1'b1; bus.a = 8'd5; bus.b = 8'd6;
        tick();
        lat++;
        bus.start = 1'b0;
        while (!bus.valid && lat < 40) begin tick(); lat++; end
        chk("ign_latency", lat, D * D + 1);
        chk("ign_p", bus.p, 63);
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        repeat (20) begin
            tick();
            chk("ign_no_valid", bus.valid, 0);
            chk("ign_no_busy", bus.busy, 0);
        end

        // reset mid-RUN, then rerun the same job
        bus.start = 1'b1; bus.a = 8'd200; bus.b = 8'd150;
        tick();
        bus.start = 1'b0;
        repeat (8) tick();
        chk("abort_busy_pre", bus.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_valid", bus.valid, 0);
        chk("abort_p", bus.p, 0);
        chk("abort_mxmy", {my, mx}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        run_job(8'd200, 8'd150, 1);

        // ack outside DONE is ignored
        bus.ack = 1'b1;
        tick();
        bus.ack = 1'b0;
        chk("ack_idle", bus.busy, 0);

        // Randomised
        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(0, 15) == 0) ra = 8'd0;
            if ($urandom_range(0, 15) == 0) rb = 8'd0;
            run_job(ra, rb, int'($urandom_range(0, 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
